uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   Receive-side byte buffer directly downstream of the UART receiver. Captures each byte
//   presented with the receiver's one-cycle ready pulse into a circular FIFO and offers it
//   to the bus/consumer through a first-word-fall-through pop interface. Detects and flags
//   overrun when bytes arrive faster than the consumer drains them.
// PARAMETERS
//   DEPTH   8   number of byte entries; power of 2, >= 2
//   WIDTH   8   data width in bits; matches receiver byte width
// PORTS
//   clk          in   1               system clock; single clock domain
//   rst_n        in   1               asynchronous active-low reset
//   rx_data      in   WIDTH           byte from receiver; valid only in rx_rdy cycle
//   rx_rdy       in   1               one-cycle pulse: rx_data holds a new byte
//   rd_en        in   1               pop request; consumes head entry this cycle
//   rd_data      out  WIDTH           head entry (FWFT); undefined when empty
//   empty        out  1               no entries held
//   full         out  1               DEPTH entries held
//   count        out  $clog2(DEPTH)+1 current occupancy, 0..DEPTH
//   overrun      out  1               sticky: a byte was dropped because FIFO was full
//   clr_overrun  in   1               clears overrun (one-cycle pulse)
// BEHAVIOUR
//   - Reset (async, rst_n low): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, overrun=0.
//     Storage array is not reset. Reset mid-burst discards all held bytes; a byte whose
//     rx_rdy coincides with reset is lost.
//   - Push: rx_rdy=1 and (!full or rd_en) -> mem[wr_ptr]<=rx_data, wr_ptr+1 at clk edge.
//     Each cycle rx_rdy is high counts as one byte (no edge detection).
//   - Pop: rd_en=1 and !empty -> rd_ptr+1 at clk edge. rd_en while empty is ignored
//     (no pointer/count change, no error flag).
//   - Pointers are $clog2(DEPTH) bits and wrap naturally DEPTH-1 -> 0.
//   - count: +1 push only, -1 pop only, unchanged when both or neither occur.
//     empty = (count==0); full = (count==DEPTH); both registered-derived, no comb. paths
//     from rx_rdy/rd_en.
//   - Latency: byte pushed at edge N is visible on rd_data, empty=0 after edge N.
//   - rd_data = mem[rd_ptr] combinationally from pointer; holds steady until popped.
//   - Simultaneous push+pop when full: both succeed, count stays DEPTH, no overrun.
//   - Simultaneous push+pop when empty: pop ignored, push succeeds, count -> 1.
//   - Overrun: rx_rdy=1, full=1, rd_en=0 -> byte dropped, storage/pointers unchanged,
//     overrun<=1. Stays set until clr_overrun. If clr_overrun and a new drop occur in
//     the same cycle, set wins (overrun stays 1).
//   - No state machine beyond pointer/count registers; overrun is an SR flop.
// STRUCTURE
//   - Shared package uart_pkg: UART_WIDTH (8), UART_RX_FIFO_DEPTH default (8),
//     typedef logic [UART_WIDTH-1:0] uart_byte_t. Module uses these for defaults/ports.
//   - One sub-module: uart_fifo_mem — DEPTH x WIDTH register array, one synchronous
//     write port (we, waddr, wdata), one asynchronous read port (raddr -> rdata).
//   - Top holds pointers, count, flag logic and push/pop qualification.
// TESTING
//   - Reset then push 0xA5 (1 rx_rdy pulse) -> next cycle empty=0, count=1, rd_data=0xA5;
//     pop -> empty=1, count=0.
//   - Push 0x00..0x07 back-to-back -> full=1, count=8; pop 8 times -> rd_data 0x00..0x07
//     in order, empty=1 after last; pointers wrapped to 0.
//   - Fill to 8, push 0xFF with rd_en=0 -> overrun=1, count=8, later pops never return
//     0xFF; clr_overrun pulse -> overrun=0.
//   - Full, rx_rdy=1 with 0x5A and rd_en=1 same cycle -> count=8, overrun=0, 0x5A
//     returned after the 7 older bytes.
//   - Empty, rd_en=1 and rx_rdy=1 (0x3C) same cycle -> count=1, rd_data=0x3C; rd_en on
//     empty alone -> count stays 0.
//   - Hold 5 bytes, assert rst_n=0 asynchronously mid-cycle -> empty=1, count=0,
//     overrun=0 immediately, before next clk edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART widths and defaults for the receive path.
package uart_pkg;

  localparam int UART_WIDTH         = 8;
  localparam int UART_RX_FIFO_DEPTH = 8;

  typedef logic [UART_WIDTH-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port.
// Write lands at the clock edge; read is combinational from raddr; storage is not reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int WIDTH = UART_WIDTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver: FWFT pop port, sticky overrun flag.
// A byte pushed at edge N is on rd_data after N; bytes arriving while full with no pop are dropped.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int WIDTH = UART_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       rx_data,
  input  logic                   rx_rdy,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overrun,
  input  logic                   clr_overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overrun;

  logic          w_push;
  logic          w_pop;
  logic          w_drop;

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a byte when read.
  assign w_push = rx_rdy && (!full || rd_en);
  assign w_pop  = rd_en && !empty;
  assign w_drop = rx_rdy && full && !rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Set has priority over clear so a drop in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (rx_data),
    .raddr (r_rd_ptr),
    .rdata (rd_data)
  );

  assign count   = r_count;
  assign empty   = (r_count == '0);
  assign full    = (r_count == CW'(DEPTH));
  assign overrun = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed vector table plus hand sequences for async reset behaviour of uart_rx_fifo.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = UART_RX_FIFO_DEPTH;
  localparam int WIDTH = UART_WIDTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] rx_data = '0;
  logic             rx_rdy = 1'b0;
  logic             rd_en = 1'b0;
  logic             clr_overrun = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             full;
  logic [3:0]       count;
  logic             overrun;

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_rdy      (rx_rdy),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rdy;
    logic [7:0] d;
    logic       rd;
    logic       clr;
    logic       e;
    logic       f;
    logic [3:0] c;
    logic       o;
    logic       cd;
    logic [7:0] xd;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic rdy, input logic [7:0] d, input logic rd,
                              input logic clr, input logic e, input logic f,
                              input logic [3:0] c, input logic o, input logic cd,
                              input logic [7:0] xd);
    vec_t v;
    v.rdy = rdy; v.d = d; v.rd = rd; v.clr = clr;
    v.e = e; v.f = f; v.c = c; v.o = o; v.cd = cd; v.xd = xd;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic e, input logic f,
                           input logic [3:0] c, input logic o);
    chk({tag, ".empty"},   32'(empty),   32'(e));
    chk({tag, ".full"},    32'(full),    32'(f));
    chk({tag, ".count"},   32'(count),   32'(c));
    chk({tag, ".overrun"}, 32'(overrun), 32'(o));
  endtask

  task automatic drive(input logic rdy, input logic [7:0] d, input logic rd, input logic clr);
    rx_rdy = rdy; rx_data = d; rd_en = rd; clr_overrun = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // --- vector table ---
    add(1, 8'hA5, 0, 0, 0, 0, 1, 0, 1, 8'hA5);
    add(0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++)
      add(1, 8'(i), 0, 0, 0, (i == 7), 4'(i + 1), 0, 1, 8'h00);
    add(1, 8'hFF, 0, 0, 0, 1, 8, 1, 1, 8'h00);
    add(0, 8'h00, 0, 0, 0, 1, 8, 1, 1, 8'h00);
    for (int k = 1; k <= 8; k++)
      add(0, 8'h00, 1, 0, (k == 8), 0, 4'(8 - k), 1, (k < 8), 8'(k));
    add(0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++)
      add(1, 8'(8'h10 + i), 0, 0, 0, (i == 7), 4'(i + 1), 0, 1, 8'h10);
    add(1, 8'h5A, 1, 0, 0, 1, 8, 0, 1, 8'h11);
    add(1, 8'hEE, 0, 1, 0, 1, 8, 1, 1, 8'h11);
    add(0, 8'h00, 0, 1, 0, 1, 8, 0, 1, 8'h11);
    for (int k = 1; k <= 7; k++)
      add(0, 8'h00, 1, 0, 0, 0, 4'(8 - k), 0, 1, (k < 7) ? 8'(8'h11 + k) : 8'h5A);
    add(0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 8'h00);
    add(1, 8'h3C, 1, 0, 0, 0, 1, 0, 1, 8'h3C);
    add(0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 8'h00);
    add(0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 8'h00);

    // --- reset state ---
    #2;
    chk_state("reset", 1, 0, 0, 0);
    #10;
    rst_n = 1'b1;
    step();
    chk_state("post_reset_idle", 1, 0, 0, 0);

    // --- table ---
    foreach (vecs[i]) begin
      drive(vecs[i].rdy, vecs[i].d, vecs[i].rd, vecs[i].clr);
      step();
      chk_state($sformatf("v%0d", i), vecs[i].e, vecs[i].f, vecs[i].c, vecs[i].o);
      if (vecs[i].cd)
        chk($sformatf("v%0d.rd_data", i), 32'(rd_data), 32'(vecs[i].xd));
    end

    // --- async reset mid-cycle with 5 bytes held and overrun set ---
    for (int i = 0; i < 8; i++) begin
      drive(1, 8'(8'h20 + i), 0, 0);
      step();
    end
    drive(1, 8'hFF, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'h00, 1, 0);
      step();
    end
    drive(0, 8'h00, 0, 0);
    chk_state("hold5", 0, 0, 5, 1);
    chk("hold5.rd_data", 32'(rd_data), 32'h23);
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 1, 0, 0, 0);

    // byte coinciding with reset is lost
    drive(1, 8'h77, 0, 0);
    step();
    chk_state("rst_rx_rdy", 1, 0, 0, 0);
    drive(0, 8'h00, 0, 0);
    #2;
    rst_n = 1'b1;
    step();
    chk_state("rst_release", 1, 0, 0, 0);

    drive(1, 8'h99, 0, 0);
    step();
    drive(0, 8'h00, 0, 0);
    chk_state("after_rst_push", 0, 0, 1, 0);
    chk("after_rst_push.rd_data", 32'(rd_data), 32'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
